// File: rtl/neuron_step_scheduler.sv
// Time-step sequencer: walks every neuron through an external potential adder,
// accumulating incoming synaptic weights between sweeps.
module neuron_step_scheduler #(
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   time_step,
    input  logic                   in_valid,
    input  logic [IDX_W-1:0]       in_idx,
    input  logic [31:0]            in_weight,
    output logic                   adder_time_step,
    output logic [31:0]            adder_weight,
    output logic [31:0]            adder_potential,
    input  logic                   adder_done,
    input  logic [31:0]            adder_final,
    input  logic                   adder_spike,
    output logic                   busy,
    output logic                   step_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   overrun,
    output logic                   timeout_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       pot_q [NUM_NEURONS];
    logic [DATA_W-1:0]       pot_d [NUM_NEURONS];
    logic [DATA_W-1:0]       acc_q [NUM_NEURONS];
    logic [DATA_W-1:0]       acc_d [NUM_NEURONS];
    logic [DATA_W-1:0]       acc_upd [NUM_NEURONS];
    logic [DATA_W:0]         acc_sum;
    logic                    in_hit;
    logic                    load;
    logic [DATA_W-1:0]       fin_q, fin_d;
    logic                    spk_q, spk_d;
    logic                    wr_q, wr_d;
    logic                    ats_q, ats_d;
    logic [DATA_W-1:0]       aw_q, aw_d;
    logic [DATA_W-1:0]       ap_q, ap_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NUM_NEURONS-1:0]  spv_q, spv_d;
    logic                    ovr_q, ovr_d;
    logic                    tmo_q, tmo_d;

    assign adder_time_step = ats_q;
    assign adder_weight    = aw_q;
    assign adder_potential = ap_q;
    assign busy            = busy_q;
    assign step_done       = done_q;
    assign spike_vec       = spv_q;
    assign overrun         = ovr_q;
    assign timeout_err     = tmo_q;

    // Sequencing, weight accumulation and registered outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pot_d   = pot_q;
        fin_d   = fin_q;
        spk_d   = spk_q;
        wr_d    = wr_q;
        ats_d   = 1'b0;
        aw_d    = aw_q;
        ap_d    = ap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        spv_d   = spv_q;
        ovr_d   = ovr_q;
        tmo_d   = tmo_q;
        load    = 1'b0;

        in_hit  = in_valid && (32'(in_idx) < NUM_NEURONS);
        acc_sum = {1'b0, acc_q[in_idx]} + {1'b0, in_weight};
        acc_upd = acc_q;
        if (in_hit) begin
            acc_upd[in_idx] = acc_sum[DATA_W] ? {DATA_W{1'b1}} : acc_sum[DATA_W-1:0];
        end
        acc_d = acc_upd;

        if (time_step && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (time_step) begin
                    idx_d   = '0;
                    spv_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                    load    = 1'b1;
                end
            end
            S_ISSUE: begin
                // A weight landing on the neuron being issued is kept for the next sweep.
                acc_d[idx_q] = (in_hit && (in_idx == idx_q)) ? in_weight : '0;
                cnt_d        = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (adder_done) begin
                    fin_d   = adder_final;
                    spk_d   = adder_spike;
                    wr_d    = 1'b1;
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    wr_d    = 1'b0;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (wr_q) begin
                    pot_d[idx_q] = fin_q;
                    spv_d[idx_q] = spk_q;
                end
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_ISSUE;
                    load    = 1'b1;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Operands are registered on ISSUE entry so they include this cycle's weight.
        if (load) begin
            ats_d = 1'b1;
            aw_d  = acc_upd[idx_d];
            ap_d  = pot_q[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i] <= '0;
                acc_q[i] <= '0;
            end
            fin_q   <= '0;
            spk_q   <= 1'b0;
            wr_q    <= 1'b0;
            ats_q   <= 1'b0;
            aw_q    <= '0;
            ap_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            spv_q   <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pot_q   <= pot_d;
            acc_q   <= acc_d;
            fin_q   <= fin_d;
            spk_q   <= spk_d;
            wr_q    <= wr_d;
            ats_q   <= ats_d;
            aw_q    <= aw_d;
            ap_q    <= ap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            spv_q   <= spv_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Bench for neuron_step_scheduler: adder model with 2-cycle latency and a
// sweep-level reference model built from the per-neuron issue schedule.
module tb_neuron_step_scheduler;

    localparam int N   = 8;
    localparam int TMO = 64;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        time_step;
    logic        in_valid;
    logic [2:0]  in_idx;
    logic [31:0] in_weight;
    logic        adder_time_step;
    logic [31:0] adder_weight;
    logic [31:0] adder_potential;
    logic        adder_done;
    logic [31:0] adder_final;
    logic        adder_spike;
    logic        busy;
    logic        step_done;
    logic [7:0]  spike_vec;
    logic        overrun;
    logic        timeout_err;

    always #5 clk = ~clk;

    neuron_step_scheduler #(.NUM_NEURONS(N), .IDX_W(3), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .time_step       (time_step),
        .in_valid        (in_valid),
        .in_idx          (in_idx),
        .in_weight       (in_weight),
        .adder_time_step (adder_time_step),
        .adder_weight    (adder_weight),
        .adder_potential (adder_potential),
        .adder_done      (adder_done),
        .adder_final     (adder_final),
        .adder_spike     (adder_spike),
        .busy            (busy),
        .step_done       (step_done),
        .spike_vec       (spike_vec),
        .overrun         (overrun),
        .timeout_err     (timeout_err)
    );

    // Potential adder: registers operands on the start pulse, done LAT cycles later.
    int          a_cnt;
    int          svc;
    int          hang_idx = -1;
    logic        m_done;
    logic [31:0] a_fin;
    logic        a_spk;
    logic        x_done = 1'b0;

    assign adder_done  = m_done | x_done;
    assign adder_final = x_done ? 32'h0BAD_0BAD : a_fin;
    assign adder_spike = x_done | a_spk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cnt  <= 0;
            svc    <= 0;
            m_done <= 1'b0;
            a_fin  <= '0;
            a_spk  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (adder_time_step) begin
                if ((svc % N) != hang_idx) a_cnt <= LAT;
                a_fin <= adder_potential + adder_weight;
                a_spk <= (32'(adder_potential + adder_weight) >= 32'd50);
                svc   <= svc + 1;
            end else if (a_cnt != 0) begin
                a_cnt <= a_cnt - 1;
                if (a_cnt == 1) m_done <= 1'b1;
            end
        end
    end

    logic [31:0] acc_m [N];
    logic [31:0] pot_m [N];
    logic [31:0] obs_w [N];
    bit          ovr_m;
    bit          tmo_m;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_w;
    } acc_vec_t;

    acc_vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        longint unsigned s;
        s = longint'(a) + longint'(b);
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    endfunction

    task automatic step(input logic ts, input logic v, input logic [2:0] idx, input logic [31:0] w);
        time_step = ts;
        in_valid  = v;
        in_idx    = idx;
        in_weight = w;
        if (v) acc_m[idx] = sat_add(acc_m[idx], w);
        @(posedge clk);
        #1;
        time_step = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            acc_m[j] = '0;
            pot_m[j] = '0;
        end
        ovr_m = 1'b0;
        tmo_m = 1'b0;
    endtask

    // One full sweep; cycle 0 carries time_step, neuron j is issued at iss[j].
    task automatic run_sweep(input int p_valid, input int mid_k, input int hang,
                             input int inj_k, input logic [2:0] inj_idx, input logic [31:0] inj_w);
        int          iss [N+1];
        int          fin;
        int          nd;
        logic [31:0] wexp [N];
        logic [7:0]  spk_m;
        logic        v;
        logic        ts;
        logic [2:0]  ri;
        logic [31:0] rw;
        nd    = 0;
        spk_m = '0;
        for (int j = 0; j <= N; j++) begin
            iss[j] = 1 + 5 * j + ((hang >= 0 && j > hang) ? (TMO - LAT - 1) : 0);
        end
        fin = iss[N];
        for (int j = 0; j < N; j++) wexp[j] = '0;
        hang_idx = hang;
        step(1'b1, 1'b0, 3'd0, 32'd0);
        for (int k = 1; k <= fin + 1; k++) begin
            if (k == 1) chk("busy_rise", busy, 1);
            if (step_done) nd++;
            for (int j = 0; j < N; j++) begin
                if (k == iss[j]) begin
                    chk("issue_pulse", adder_time_step, 1);
                    chk("issue_weight", adder_weight, acc_m[j]);
                    chk("issue_potential", adder_potential, pot_m[j]);
                    obs_w[j] = adder_weight;
                    wexp[j]  = acc_m[j];
                    acc_m[j] = '0;
                end
            end
            if (k == fin) chk("step_done_cycle", step_done, 1);
            if (hang >= 0 && k == iss[hang+1] - 2) chk("timeout_before", timeout_err, tmo_m);
            if (hang >= 0 && k == iss[hang+1] - 1) begin
                chk("timeout_set", timeout_err, 1);
                tmo_m = 1'b1;
            end
            if (k == fin + 1) begin
                chk("busy_fall", busy, 0);
                chk("done_count", nd, 1);
                for (int j = 0; j < N; j++) begin
                    if (j != hang) begin
                        pot_m[j] = pot_m[j] + wexp[j];
                        spk_m[j] = (pot_m[j] >= 32'd50);
                    end
                end
                chk("spike_vec", spike_vec, spk_m);
                chk("overrun", overrun, ovr_m);
                chk("timeout_err", timeout_err, tmo_m);
            end else begin
                v  = ($urandom_range(0, 99) < p_valid);
                ri = 3'($urandom_range(0, N - 1));
                rw = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 30);
                if (k == inj_k) begin
                    v  = 1'b1;
                    ri = inj_idx;
                    rw = inj_w;
                end
                ts = (k == mid_k);
                if (ts) ovr_m = 1'b1;
                step(ts, v, ri, rw);
            end
        end
        hang_idx = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        tbl[0] = '{3'd2, 32'hFFFF_FFF0, 32'h0000_0020, 32'hFFFF_FFFF};
        tbl[1] = '{3'd0, 32'd1,         32'd2,         32'd3};
        tbl[2] = '{3'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        tbl[3] = '{3'd5, 32'd0,         32'd0,         32'd0};
        tbl[4] = '{3'd6, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};

        rst = 1'b0; time_step = 1'b0; in_valid = 1'b0; in_idx = '0; in_weight = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ats", adder_time_step, 0);
        chk("rst_aw", adder_weight, 0);
        chk("rst_ap", adder_potential, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", step_done, 0);
        chk("rst_spike", spike_vec, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic sweep: two weights, only neuron 1 crosses threshold.
        step(1'b0, 1'b1, 3'd0, 32'd25);
        step(1'b0, 1'b1, 3'd1, 32'd60);
        run_sweep(0, -1, -1, -1, 3'd0, 32'd0);
        chk("basic_spike_vec", spike_vec, 8'b0000_0010);

        // Accumulation and saturation table.
        for (int t = 0; t < 5; t++) begin
            step(1'b0, 1'b1, tbl[t].idx, tbl[t].w0);
            step(1'b0, 1'b1, tbl[t].idx, tbl[t].w1);
            run_sweep(0, -1, -1, -1, 3'd0, 32'd0);
            chk("tbl_acc", obs_w[tbl[t].idx], tbl[t].exp_w);
        end

        // Weight arriving in neuron 3's issue cycle goes to the next sweep.
        step(1'b0, 1'b1, 3'd3, 32'd4);
        run_sweep(0, -1, -1, 16, 3'd3, 32'd7);
        chk("issue_hit_old", obs_w[3], 4);
        run_sweep(0, -1, -1, -1, 3'd0, 32'd0);
        chk("issue_hit_next", obs_w[3], 7);

        // time_step mid-sweep: overrun, one step_done, same length.
        run_sweep(0, 17, -1, -1, 3'd0, 32'd0);

        // Stray adder_done while idle must not disturb anything.
        x_done = 1'b1;
        step(1'b0, 1'b0, 3'd0, 32'd0);
        x_done = 1'b0;
        chk("stray_done_busy", busy, 0);
        run_sweep(0, -1, -1, -1, 3'd0, 32'd0);

        // Randomized traffic across sweeps and idle gaps.
        for (int r = 0; r < 6; r++) begin
            cnt = $urandom_range(0, 4);
            for (int g = 0; g < cnt; g++) begin
                step(1'b0, 1'b1, 3'($urandom_range(0, N - 1)), $urandom_range(0, 40));
            end
            run_sweep(30, -1, -1, -1, 3'd0, 32'd0);
        end

        // Adder never answers for neuron 4.
        run_sweep(20, -1, 4, -1, 3'd0, 32'd0);
        run_sweep(0, -1, -1, -1, 3'd0, 32'd0);

        // Reset during neuron 5's wait.
        step(1'b1, 1'b0, 3'd0, 32'd0);
        for (int k = 1; k < 27; k++) step(1'b0, 1'b0, 3'd0, 32'd0);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ats", adder_time_step, 0);
        chk("mid_rst_aw", adder_weight, 0);
        chk("mid_rst_ap", adder_potential, 0);
        chk("mid_rst_spike", spike_vec, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            if (busy || step_done) cnt++;
            step(1'b0, 1'b0, 3'd0, 32'd0);
        end
        chk("post_rst_quiet", cnt, 0);
        step(1'b0, 1'b1, 3'd5, 32'd55);
        step(1'b0, 1'b1, 3'd2, 32'd10);
        run_sweep(0, -1, -1, -1, 3'd0, 32'd0);
        chk("post_rst_spike_vec", spike_vec, 8'b0010_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
